serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial ripple-borrow subtractor computing `a - b - bin` one bit per clock, LSB first, with a start/done handshake. It is the sequential inverse companion of the structural 4-bit ripple adder in `comblogic`, and its default width and vectors match that adder's operand set. Area is traded for latency: one full-subtractor cell, operand shift registers and a small FSM.

## Interface
- `WIDTH`, default 4: operand and result width in bits; must be ≥ 2.
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `start` input 1: request a subtraction; sampled only in IDLE.
- `a` input WIDTH: minuend; captured on the accepting edge.
- `b` input WIDTH: subtrahend; captured on the accepting edge.
- `bin` input 1: borrow-in; captured on the accepting edge.
- `busy` output 1: high while RUN.
- `done` output 1: one-cycle pulse; result is valid.
- `diff` output WIDTH: difference, modulo 2^WIDTH.
- `bout` output 1: borrow-out; 1 when `a < b + bin` (unsigned).
- `ovf` output 1: signed two's-complement overflow. Present only with `SERIAL_SUB_OVF_EN`.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on `start`=1.
  - RUN→DONE after the WIDTH-th bit.
  - DONE→IDLE unconditionally.
- Accept (IDLE, `start`=1):
  - Load `a` and `b` into shift registers.
  - Load the borrow flop with `bin`.
  - Clear the bit counter.
  - Clear the internal difference shift register.
- RUN, each edge:
  - d = a0 ^ b0 ^ br.
  - br' = (~a0 & b0) | (~(a0 ^ b0) & br).
  - Shift `a` and `b` right.
  - Shift d into the MSB of the internal difference register.
  - Increment the counter.
- Completion (edge processing bit WIDTH-1):
  - Copy the internal register, with that final d merged, into `diff`.
  - Set `bout` = br'.
  - With the macro: `ovf` = (borrow into MSB) ^ br'.
- `diff`, `bout` and `ovf` are output registers. They change only at completion or reset, and hold the previous result through IDLE and RUN.
- `start` while RUN or DONE: ignored, not queued. Operands must be re-presented in IDLE.
- `start` held high continuously: a new operation is accepted each time IDLE is re-entered.

## Timing
- Reset (`rst_n`=0 at an edge):
  - State goes to IDLE.
  - `busy`=0, `done`=0, `diff`=0, `bout`=0, `ovf`=0.
  - Internal registers and counter are cleared.
  - Reset mid-RUN abandons the operation; no `done` is produced.
- Reset has priority over `start` on the same edge.
- Accept at edge E0:
  - `busy`=1 from after E0 until after E(WIDTH).
  - Bits are processed on edges E1..E(WIDTH).
  - After E(WIDTH): `done`=1 and `busy`=0 for exactly one cycle (DONE), and the new `diff`/`bout` are visible.
- Latency: WIDTH cycles from accept to `done`.
- Back-to-back issue: next accept earliest at E(WIDTH+2), giving a throughput of one result per WIDTH+2 cycles.
- `busy` and `done` are never high simultaneously.

## Configuration
- `SERIAL_SUB_OVF_EN` defined:
  - `ovf` port exists.
  - The MSB-borrow capture flop exists.
  - `ovf` updates with `diff` at completion.
- Undefined: no `ovf` port and no related logic. All other behaviour and timing are identical.

## Test plan
- Reset then idle: `rst_n`=0 for 2 edges, `start`=0 → `busy`=0, `done`=0, `diff`=0000, `bout`=0 on every cycle.
- Operand vectors, WIDTH=4, one at a time, `done` checked exactly 4 cycles after accept:
  - 1010−1100, bin 0 → `diff`=1110, `bout`=1.
  - 0010−1110, bin 1 → `diff`=0011, `bout`=1.
  - 1111−1111, bin 0 → `diff`=0000, `bout`=0.
  - 1001−1101, bin 1 → `diff`=1011, `bout`=1.
- Overflow (macro on):
  - 0111−1000, bin 0 → `diff`=1111, `bout`=1, `ovf`=1.
  - 1010−1100 → `ovf`=0.
  - Build with macro off → compiles, same `diff` and `bout`.
- Busy-ignore: accept 0101−0011 (bin 0), then pulse `start` with 1111−0000 at cycle 2 → single `done`, `diff`=0010, `bout`=0; no second `done` follows.
- Reset mid-op: accept 1000−0001, drop `rst_n` at cycle 2 → no `done`, all outputs 0; a fresh 0100−0001 after reset → `diff`=0011.
- Continuous `start`=1 with 0110−0010: `done` pulses every 6 cycles, `diff`=0100 each time.

Source files
------------

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial ripple-borrow subtractor: computes a - b - bin one bit per clock,
// LSB first, using a single full-subtractor cell, two operand shift registers,
// a partial-difference shift register and a three-state FSM.
//
// A request is accepted in IDLE when start=1. The WIDTH bits are then processed
// on the following WIDTH rising edges (RUN), after which done pulses for one
// cycle (DONE) with the new result on diff/bout. The result outputs are
// registers that hold the previous result until the next completion or reset.
//
// Optional feature macro:
//   SERIAL_SUB_OVF_EN - adds the ovf output (signed two's-complement overflow)
//                       and its result register.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst_n  in   1      synchronous active-low reset
//   start  in   1      request a subtraction (sampled only in IDLE)
//   a      in   WIDTH  minuend, captured on the accepting edge
//   b      in   WIDTH  subtrahend, captured on the accepting edge
//   bin    in   1      borrow-in, captured on the accepting edge
//   busy   out  1      high while bits are being processed
//   done   out  1      one-cycle pulse, result valid
//   diff   out  WIDTH  difference modulo 2^WIDTH
//   bout   out  1      borrow-out (a < b + bin, unsigned)
//   ovf    out  1      signed overflow (only with SERIAL_SUB_OVF_EN)
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Bit counter only needs to reach WIDTH-1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] d_sr;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             a0;
  logic             b0;
  logic             d_bit;
  logic             br_nxt;
  logic             accept;
  logic             last_bit;

  // ---------------------------------------------------------------------------
  // Full-subtractor cell and control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    a0       = a_sr[0];
    b0       = b_sr[0];
    d_bit    = a0 ^ b0 ^ br;
    br_nxt   = (~a0 & b0) | (~(a0 ^ b0) & br);
    accept   = (state == IDLE) && start;
    last_bit = (state == RUN) && (cnt == CW'(WIDTH - 1));
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of block ordering in simulation.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and Moore outputs
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default before the case so that no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand/difference shift registers, borrow flop, bit counter
  // ---------------------------------------------------------------------------
  // NOTE: these registers are plain flops rather than a memory array, so they
  // are cleared on reset at no real cost; this also guarantees an abandoned
  // operation leaves nothing behind.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr <= '0;
      b_sr <= '0;
      d_sr <= '0;
      br   <= 1'b0;
      cnt  <= '0;
    end else if (accept) begin
      a_sr <= a;
      b_sr <= b;
      d_sr <= '0;
      br   <= bin;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sr <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr <= {1'b0, b_sr[WIDTH-1:1]};
      // New bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
      d_sr <= {d_bit, d_sr[WIDTH-1:1]};
      br   <= br_nxt;
      cnt  <= cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Result registers: updated only on the edge that processes the MSB
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      diff <= '0;
      bout <= 1'b0;
    end else if (last_bit) begin
      // The final bit is merged directly rather than waiting for d_sr.
      diff <= {d_bit, d_sr[WIDTH-1:1]};
      bout <= br_nxt;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // While the MSB is processed, br holds the borrow into the MSB, so signed
  // overflow is that borrow XOR the borrow out of the MSB.
  always_ff @(posedge clk) begin
    if (!rst_n)        ovf <= 1'b0;
    else if (last_bit) ovf <= br ^ br_nxt;
  end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Self-checking bench for serial_subtractor (WIDTH=4). A behavioural model
// tracks, per cycle, how long ago the current request was accepted and the
// arithmetic result it must produce; a compare process checks every DUT
// output against it on each falling edge. Directed scenarios add literal
// expectations for the reference vectors, busy-ignore, reset mid-operation
// and continuous start. Works with or without SERIAL_SUB_OVF_EN.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // t = -1 when idle, otherwise cycles since the accepting edge (0..W).
  // ---------------------------------------------------------------------------
  int           t       = -1;
  bit           m_valid = 1'b0;
  logic [W-1:0] m_diff, p_diff;
  logic         m_bout, p_bout;
  logic         m_ovf, p_ovf;

  always @(posedge clk) begin
    int full, sa, sb, r;
    if (!rst_n) begin
      t = -1; m_diff = '0; m_bout = 1'b0; m_ovf = 1'b0; m_valid = 1'b1;
    end else if (t == W) begin
      t = -1;                       // one cycle of done, start ignored
    end else if (t >= 0) begin
      t++;
      if (t == W) begin
        m_diff = p_diff; m_bout = p_bout; m_ovf = p_ovf;
      end
    end else if (start) begin
      t      = 0;
      full   = int'(a) - int'(b) - int'(bin);
      p_diff = full[W-1:0];
      p_bout = (full < 0);
      sa     = a[W-1] ? int'(a) - (1 << W) : int'(a);
      sb     = b[W-1] ? int'(b) - (1 << W) : int'(b);
      r      = sa - sb - int'(bin);
      p_ovf  = (r < -(1 << (W-1))) || (r > (1 << (W-1)) - 1);
    end
  end

  // Compare process: every cycle once the model has seen reset.
  always @(negedge clk) begin
    if (m_valid) begin
      check("busy", 32'(busy), 32'(t >= 0 && t < W));
      check("done", 32'(done), 32'(t == W));
      check("diff", 32'(diff), 32'(m_diff));
      check("bout", 32'(bout), 32'(m_bout));
`ifdef SERIAL_SUB_OVF_EN
      check("ovf",  32'(ovf),  32'(m_ovf));
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Directed single operation with literal expectations. Called at a falling
  // edge while the DUT is idle; returns at a falling edge with the DUT idle.
  // ---------------------------------------------------------------------------
  task automatic op(input string nm, input logic [W-1:0] ia, input logic [W-1:0] ib,
                    input logic ibin, input logic [W-1:0] ed, input logic eb, input logic eo);
    a = ia; b = ib; bin = ibin; start = 1'b1;
    @(negedge clk);                 // after accepting edge
    start = 1'b0;
    check({nm, "_busy"}, 32'(busy), 32'd1);
    repeat (W) @(negedge clk);      // after edge W: done exactly here
    check({nm, "_done"}, 32'(done), 32'd1);
    check({nm, "_diff"}, 32'(diff), 32'(ed));
    check({nm, "_bout"}, 32'(bout), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
    check({nm, "_ovf"},  32'(ovf),  32'(eo));
`else
    if (eo) begin end               // ovf expectation unused without the feature
`endif
    @(negedge clk);
  endtask

  initial begin
    int n_done;
    int last_done;
    int n_cyc;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;

    // Reset then idle
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reference vectors
    op("v1", 4'b1010, 4'b1100, 1'b0, 4'b1110, 1'b1, 1'b0);
    op("v2", 4'b0010, 4'b1110, 1'b1, 4'b0011, 1'b1, 1'b0);
    op("v3", 4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0);
    op("v4", 4'b1001, 4'b1101, 1'b1, 4'b1011, 1'b1, 1'b0);
    op("ovf1", 4'b0111, 4'b1000, 1'b0, 4'b1111, 1'b1, 1'b1);
    op("ovf2", 4'b1010, 4'b1100, 1'b0, 4'b1110, 1'b1, 1'b0);

    // Busy-ignore: second start during RUN must not be queued
    a = 4'b0101; b = 4'b0011; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 4'b1111; b = 4'b0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_done = 0;
    for (int i = 0; i < 2 * W + 4; i++) begin
      if (done) begin
        n_done++;
        check("bsy_diff", 32'(diff), 32'(4'b0010));
        check("bsy_bout", 32'(bout), 32'd0);
      end
      @(negedge clk);
    end
    check("bsy_ndone", 32'(n_done), 32'd1);

    // Reset mid-operation
    a = 4'b1000; b = 4'b0001; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_diff", 32'(diff), 32'd0);
    check("mid_bout", 32'(bout), 32'd0);
    n_done = 0;
    for (int i = 0; i < W + 3; i++) begin
      if (done) n_done++;
      @(negedge clk);
    end
    check("mid_ndone", 32'(n_done), 32'd0);
    op("fresh", 4'b0100, 4'b0001, 1'b0, 4'b0011, 1'b0, 1'b0);

    // Continuous start: one result every W+2 cycles
    a = 4'b0110; b = 4'b0010; bin = 1'b0; start = 1'b1;
    n_done = 0; last_done = -1; n_cyc = 0;
    for (int i = 0; i < 5 * (W + 2); i++) begin
      @(negedge clk);
      n_cyc++;
      if (done) begin
        if (last_done >= 0) check("cont_period", 32'(n_cyc - last_done), 32'(W + 2));
        check("cont_diff", 32'(diff), 32'(4'b0100));
        last_done = n_cyc;
        n_done++;
      end
    end
    start = 1'b0;
    check("cont_ndone", 32'(n_done >= 4), 32'd1);
    repeat (W + 2) @(negedge clk);

    // Randomized traffic: random starts (including while busy) and operands
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 2) == 0);
      a     = W'($urandom);
      b     = W'($urandom);
      bin   = 1'($urandom);
      if ($urandom_range(0, 150) == 0) rst_n = 1'b0;
      else                             rst_n = 1'b1;
      @(negedge clk);
    end
    start = 1'b0; rst_n = 1'b1;
    repeat (W + 3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
